// File: rtl/spi_mem_sequencer.sv
// spi_mem_sequencer
//   Sits between an SPI slave's 10-bit receive stream and a single-port
//   synchronous byte RAM. Each received word is decoded by bits [9:8]:
//     00 set write address, 01 write data, 10 set read address, 11 read.
//   Generates one-cycle RAM write/read strobes, returns read bytes through a
//   level tx_data/tx_valid handshake and counts protocol errors.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ss_n              SPI slave select (active-low, same clock domain)
//   rx_data/rx_valid  received word and its valid level
//   tx_data/tx_valid  read byte back to the slave, held until ss_n rises
//   mem_*             RAM write/read strobes, address, write and read data
//   cmd_err/err_cnt   one-cycle error pulse and saturating error count
//   busy              high whenever the sequencer is not idle
module spi_mem_sequencer #(
  parameter int ADDR_SIZE  = 8,
  parameter int RD_LATENCY = 1,
  parameter int AUTO_INC   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ss_n,
  input  logic [9:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  output logic                 mem_we,
  output logic                 mem_re,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata,
  output logic                 cmd_err,
  output logic [7:0]           err_cnt,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_MEM, S_RD_ISSUE, S_RD_WAIT, S_TX_HOLD
  } state_t;

  state_t                 state_q, state_d;
  logic                   rx_valid_q;
  logic [ADDR_SIZE-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0]   rd_addr_q, rd_addr_d;
  logic                   wr_addr_vld_q, wr_addr_vld_d;
  logic                   rd_addr_vld_q, rd_addr_vld_d;
  logic [1:0]             lat_q, lat_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   tx_valid_q, tx_valid_d;
  logic                   mem_we_q, mem_we_d;
  logic                   mem_re_q, mem_re_d;
  logic [ADDR_SIZE-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]             mem_wdata_q, mem_wdata_d;
  logic                   cmd_err_q, cmd_err_d;
  logic [7:0]             err_cnt_q, err_cnt_d;
  logic                   busy_q;

  logic                   rx_rise;
  logic                   err;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign rx_rise = rx_valid & ~rx_valid_q;

  always_comb begin
    state_d       = state_q;
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    wr_addr_vld_d = wr_addr_vld_q;
    rd_addr_vld_d = rd_addr_vld_q;
    lat_d         = lat_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q;
    mem_we_d      = 1'b0;
    mem_re_d      = 1'b0;
    mem_addr_d    = '0;
    mem_wdata_d   = 8'h00;
    err           = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_rise) begin
          case (rx_data[9:8])
            2'b00: begin
              wr_addr_d     = rx_data[ADDR_SIZE-1:0];
              wr_addr_vld_d = 1'b1;
            end
            2'b01: begin
              if (wr_addr_vld_q) begin
                state_d     = S_WR_MEM;
                mem_we_d    = 1'b1;
                mem_addr_d  = wr_addr_q;
                mem_wdata_d = rx_data[7:0];
              end else begin
                err = 1'b1;
              end
            end
            2'b10: begin
              rd_addr_d     = rx_data[ADDR_SIZE-1:0];
              rd_addr_vld_d = 1'b1;
            end
            default: begin
              if (rd_addr_vld_q) begin
                state_d    = S_RD_ISSUE;
                mem_re_d   = 1'b1;
                mem_addr_d = rd_addr_q;
              end else begin
                err = 1'b1;
              end
            end
          endcase
        end
      end
      S_WR_MEM: begin
        if (AUTO_INC != 0) wr_addr_d = wr_addr_q + 1'b1;
        state_d = S_IDLE;
      end
      S_RD_ISSUE: begin
        // The address is consumed by the read whether or not it completes.
        rd_addr_vld_d = 1'b0;
        lat_d         = 2'(RD_LATENCY - 1);
        state_d       = ss_n ? S_IDLE : S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // Abort wins over capture so no tx_valid is raised once ss_n rises.
        if (ss_n) begin
          state_d = S_IDLE;
        end else if (lat_q == 2'd0) begin
          tx_data_d  = mem_rdata;
          tx_valid_d = 1'b1;
          state_d    = S_TX_HOLD;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      S_TX_HOLD: begin
        if (ss_n) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Any new word arriving while a transaction is in flight is dropped.
    if (rx_rise && state_q != S_IDLE) err = 1'b1;

    cmd_err_d = err;
    err_cnt_d = err ? sat_inc(err_cnt_q) : err_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rx_valid_q    <= 1'b0;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      wr_addr_vld_q <= 1'b0;
      rd_addr_vld_q <= 1'b0;
      lat_q         <= 2'd0;
      tx_data_q     <= 8'h00;
      tx_valid_q    <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_re_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= 8'h00;
      cmd_err_q     <= 1'b0;
      err_cnt_q     <= 8'h00;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_valid_q    <= rx_valid;
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      wr_addr_vld_q <= wr_addr_vld_d;
      rd_addr_vld_q <= rd_addr_vld_d;
      lat_q         <= lat_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      mem_we_q      <= mem_we_d;
      mem_re_q      <= mem_re_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      cmd_err_q     <= cmd_err_d;
      err_cnt_q     <= err_cnt_d;
      busy_q        <= (state_d != S_IDLE);
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cmd_err   = cmd_err_q;
  assign err_cnt   = err_cnt_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spi_mem_sequencer.sv
// tb_spi_mem_sequencer
//   Scoreboard bench for spi_mem_sequencer. Instance u_dut uses the default
//   parameters (RD_LATENCY=1, AUTO_INC=1); u_dut_b uses RD_LATENCY=3 for the
//   abort-in-wait scenario. Expected writes, reads, read data and error
//   counts are queued as words are driven and popped as the DUT produces them.
module tb_spi_mem_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  always #5 clk = ~clk;

  // Instance A
  logic       ss_n, rx_valid, tx_valid, mem_we, mem_re, cmd_err, busy;
  logic [9:0] rx_data;
  logic [7:0] tx_data, mem_addr, mem_wdata, mem_rdata, err_cnt;
  // Instance B
  logic       ss_n_b, rx_valid_b, tx_valid_b, mem_we_b, mem_re_b, cmd_err_b, busy_b;
  logic [9:0] rx_data_b;
  logic [7:0] tx_data_b, mem_addr_b, mem_wdata_b, mem_rdata_b, err_cnt_b;

  spi_mem_sequencer #(.ADDR_SIZE(8), .RD_LATENCY(1), .AUTO_INC(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .ss_n(ss_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .mem_we(mem_we), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cmd_err(cmd_err), .err_cnt(err_cnt), .busy(busy)
  );

  spi_mem_sequencer #(.ADDR_SIZE(8), .RD_LATENCY(3), .AUTO_INC(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .ss_n(ss_n_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .mem_we(mem_we_b), .mem_re(mem_re_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b),
    .cmd_err(cmd_err_b), .err_cnt(err_cnt_b), .busy(busy_b)
  );

  // RAM A: one-edge read latency
  logic [7:0] ram_a [256];
  always @(posedge clk) begin
    if (mem_we) ram_a[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram_a[mem_addr];
  end

  // RAM B: three-edge read latency, content is a fixed function of address
  logic [7:0] pb0, pb1, pb2;
  always @(posedge clk) begin
    if (mem_re_b) pb0 <= mem_addr_b ^ 8'h3C;
    pb1 <= pb0;
    pb2 <= pb1;
  end
  assign mem_rdata_b = pb2;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Scoreboard queues and reference model state
  logic [15:0] wr_q [$];
  logic [7:0]  re_q [$];
  logic [7:0]  rd_q [$];
  logic [7:0]  err_q [$];
  logic [7:0]  shadow [256];
  logic [7:0]  m_wa, m_ra, err_exp;
  logic        m_wv, m_rv;

  task automatic model_reset();
    m_wa = 8'h00; m_ra = 8'h00; m_wv = 1'b0; m_rv = 1'b0; err_exp = 8'h00;
  endtask

  task automatic push_err();
    if (err_exp != 8'hFF) err_exp = err_exp + 8'd1;
    err_q.push_back(err_exp);
  endtask

  // Drive one word to instance A (assumed idle), holding rx_valid 3 cycles.
  task automatic send(input logic [9:0] w);
    logic [7:0] p;
    p = w[7:0];
    case (w[9:8])
      2'b00: begin m_wa = p; m_wv = 1'b1; end
      2'b01: begin
        if (m_wv) begin
          wr_q.push_back({m_wa, p});
          shadow[m_wa] = p;
          m_wa = m_wa + 8'd1;
        end else push_err();
      end
      2'b10: begin m_ra = p; m_rv = 1'b1; end
      default: begin
        if (m_rv) begin
          re_q.push_back(m_ra);
          rd_q.push_back(shadow[m_ra]);
          m_rv = 1'b0;
        end else push_err();
      end
    endcase
    @(posedge clk); #1;
    rx_data = w; rx_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_ss();
    ss_n = 1'b1;
    @(posedge clk); #1;
    chk("tx_drop", tx_valid, 1'b0);
    chk("busy_after_tx", busy, 1'b0);
    ss_n = 1'b0;
    @(posedge clk); #1;
  endtask

  // Monitor A
  logic tv_prev = 1'b0;
  always @(negedge clk) begin
    logic [15:0] e;
    if (mem_we) begin
      chk("we_re_excl", mem_re, 1'b0);
      if (wr_q.size() == 0) chk("wr_unexpected", mem_we, 1'b0);
      else begin
        e = wr_q.pop_front();
        chk("wr_addr", mem_addr, e[15:8]);
        chk("wr_data", mem_wdata, e[7:0]);
      end
    end
    if (mem_re) begin
      if (re_q.size() == 0) chk("re_unexpected", mem_re, 1'b0);
      else chk("re_addr", mem_addr, re_q.pop_front());
    end
    if (!mem_we && !mem_re && mem_addr != 8'h00) chk("addr_idle", mem_addr, 8'h00);
    if (tx_valid && !tv_prev) begin
      if (rd_q.size() == 0) chk("tx_unexpected", tx_valid, 1'b0);
      else chk("tx_data", tx_data, rd_q.pop_front());
    end
    tv_prev = tx_valid;
    if (cmd_err) begin
      if (err_q.size() == 0) chk("err_unexpected", cmd_err, 1'b0);
      else chk("err_cnt", err_cnt, err_q.pop_front());
    end
  end

  // Monitor B
  int tvb_seen = 0, errb_seen = 0, reb_seen = 0;
  always @(negedge clk) begin
    if (tx_valid_b) tvb_seen++;
    if (cmd_err_b) errb_seen++;
    if (mem_re_b) reb_seen++;
  end

  initial begin
    rst_n = 1'b0; ss_n = 1'b0; rx_data = '0; rx_valid = 1'b0;
    ss_n_b = 1'b0; rx_data_b = '0; rx_valid_b = 1'b0;
    model_reset();
    #12;
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_re", mem_re, 1'b0);
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_cmd_err", cmd_err, 1'b0);
    chk("rst_err_cnt", err_cnt, 8'h00);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    // Set address, write, then auto-increment check via a second write
    send(10'h005);
    send(10'h1A5);
    send(10'h1B6);          // lands at 6
    // Wrap of the write address
    send(10'h0FF);
    send(10'h111);
    send(10'h122);          // lands at 0
    // Read path with latency 1
    send(10'h005);
    send(10'h15C);
    send(10'h205);
    send(10'h300);
    repeat (4) @(posedge clk);
    #1;
    chk("tx_hold_valid", tx_valid, 1'b1);
    chk("tx_hold_data", tx_data, 8'h5C);
    chk("tx_hold_busy", busy, 1'b1);
    release_ss();
    chk("tx_data_kept", tx_data, 8'h5C);
    send(10'h300);          // address consumed: error, err_cnt=1
    send(10'h206);
    send(10'h300);          // reads back 0xB6
    release_ss();

    // Error saturation from a fresh reset
    @(negedge clk) rst_n = 1'b0;
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 300; i++) send(10'h1AA);
    chk("err_sat", err_cnt, 8'hFF);

    // Asynchronous reset while holding read data
    send(10'h007);
    send(10'h1C3);
    send(10'h207);
    send(10'h300);
    chk("pre_rst_tx_valid", tx_valid, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_tx_valid", tx_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_mem_we", mem_we, 1'b0);
    chk("arst_mem_re", mem_re, 1'b0);
    chk("arst_err_cnt", err_cnt, 8'h00);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    send(10'h1AA);
    send(10'h155);

    // Instance B: abort during RD_WAIT with latency 3
    @(posedge clk); #1;
    rx_data_b = 10'h205; rx_valid_b = 1'b1;
    repeat (3) @(posedge clk);
    #1 rx_valid_b = 1'b0;
    repeat (2) @(posedge clk);
    #1 rx_data_b = 10'h300; rx_valid_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("b_busy_in_wait", busy_b, 1'b1);
    ss_n_b = 1'b1; rx_valid_b = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("b_busy_after_abort", busy_b, 1'b0);
    chk("b_tx_valid_seen", tvb_seen, 0);
    chk("b_re_pulses", reb_seen, 1);
    chk("b_no_err_yet", errb_seen, 0);
    ss_n_b = 1'b0;
    rx_data_b = 10'h300; rx_valid_b = 1'b1;
    repeat (3) @(posedge clk);
    #1 rx_valid_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("b_err_pulses", errb_seen, 1);
    chk("b_err_cnt", err_cnt_b, 8'h01);
    chk("b_re_no_extra", reb_seen, 1);

    chk("wr_q_empty", wr_q.size(), 0);
    chk("re_q_empty", re_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    chk("err_q_empty", err_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
